// File: rtl/riscv_multicycle_ref_model_if.sv
// rtl/riscv_multicycle_ref_model_if.sv - instruction handshake and retire port bundle
interface riscv_multicycle_ref_model_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [4:0]      retire_rd;
  logic            retire_we;
  logic [XLEN-1:0] retire_data;
  logic            retire_illegal;

  modport master (
    output inst_valid, inst,
    input  inst_ready, retire_valid, retire_pc, retire_rd, retire_we, retire_data, retire_illegal
  );

  modport slave (
    input  inst_valid, inst,
    output inst_ready, retire_valid, retire_pc, retire_rd, retire_we, retire_data, retire_illegal
  );
endinterface

// File: rtl/riscv_multicycle_ref_model.sv
// rtl/riscv_multicycle_ref_model.sv - multi-cycle RV32I-subset architectural reference hart
module riscv_multicycle_ref_model #(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  riscv_multicycle_ref_model_if.slave bus,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN*NUM_REGS-1:0] port_regfile
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OP_REG = 7'h33, OP_IMM = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BRANCH = 7'h63;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_READ, S_EXEC, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] imm_q, rs1_q, rs2_q, result_q, next_pc_q, pc_q;
  logic            legal_q, writes_q, illegal_q, we_q;
  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic [6:0] opcode, funct7, sh_hi;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign funct7 = inst_q[31:25];
  // RV64 shift-immediates carry a 6-bit shamt, leaving only funct6 to validate
  assign sh_hi  = (XLEN == 64) ? {inst_q[31:26], 1'b0} : inst_q[31:25];

  function automatic logic bad_idx(input logic [4:0] idx);
    return 32'(idx) >= 32'(NUM_REGS);
  endfunction

  logic [XLEN-1:0] imm_d;
  logic            legal_d, writes_d, use_rs1, use_rs2, use_rd;

  always_comb begin
    imm_d    = XLEN'($signed(inst_q[31:20]));
    legal_d  = 1'b1;
    writes_d = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    case (opcode)
      OP_REG: begin
        {writes_d, use_rs1, use_rs2, use_rd} = 4'b1111;
        legal_d = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      OP_IMM: begin
        {writes_d, use_rs1, use_rd} = 3'b111;
        if (funct3 == 3'd1)      legal_d = (sh_hi == 7'h00);
        else if (funct3 == 3'd5) legal_d = (sh_hi == 7'h00) || (sh_hi == 7'h20);
      end
      OP_LUI, OP_AUIPC: begin
        {writes_d, use_rd} = 2'b11;
        imm_d = XLEN'($signed({inst_q[31:12], 12'b0}));
      end
      OP_JAL: begin
        {writes_d, use_rd} = 2'b11;
        imm_d = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
      end
      OP_JALR: begin
        {writes_d, use_rs1, use_rd} = 3'b111;
        legal_d = (funct3 == 3'd0);
      end
      OP_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        imm_d   = XLEN'($signed({inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0}));
        legal_d = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      default: legal_d = 1'b0;
    endcase
    if ((use_rs1 && bad_idx(rs1)) || (use_rs2 && bad_idx(rs2)) || (use_rd && bad_idx(rd)))
      legal_d = 1'b0;
  end

  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == 5'(i)) rs1_val = regs_q[i];
      if (rs2 == 5'(i)) rs2_val = regs_q[i];
    end
  end

  logic [XLEN-1:0]        op_b, alu_res, result_d, next_pc_d, pc_plus4;
  logic signed [XLEN-1:0] sra_res;
  logic [SHW-1:0]         shamt;
  logic                   taken, jump, misalign;

  always_comb begin
    op_b     = (opcode == OP_REG) ? rs2_q : imm_q;
    shamt    = op_b[SHW-1:0];
    sra_res  = $signed(rs1_q) >>> shamt;
    pc_plus4 = pc_q + XLEN'(4);
    case (funct3)
      3'd0:    alu_res = (opcode == OP_REG && funct7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'd1:    alu_res = rs1_q << shamt;
      3'd2:    alu_res = XLEN'($signed(rs1_q) < $signed(op_b));
      3'd3:    alu_res = XLEN'(rs1_q < op_b);
      3'd4:    alu_res = rs1_q ^ op_b;
      3'd5:    alu_res = inst_q[30] ? sra_res : rs1_q >> shamt;
      3'd6:    alu_res = rs1_q | op_b;
      default: alu_res = rs1_q & op_b;
    endcase
    result_d  = alu_res;
    next_pc_d = pc_plus4;
    taken     = 1'b0;
    jump      = 1'b0;
    case (opcode)
      OP_LUI:   result_d = imm_q;
      OP_AUIPC: result_d = pc_q + imm_q;
      OP_JAL: begin
        result_d  = pc_plus4;
        next_pc_d = pc_q + imm_q;
        jump      = 1'b1;
      end
      OP_JALR: begin
        result_d  = pc_plus4;
        next_pc_d = (rs1_q + imm_q) & ~XLEN'(1);
        jump      = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    taken = (rs1_q == rs2_q);
          3'd1:    taken = (rs1_q != rs2_q);
          3'd4:    taken = ($signed(rs1_q) < $signed(rs2_q));
          3'd5:    taken = ($signed(rs1_q) >= $signed(rs2_q));
          3'd6:    taken = (rs1_q < rs2_q);
          3'd7:    taken = (rs1_q >= rs2_q);
          default: taken = 1'b0;
        endcase
        if (taken) next_pc_d = pc_q + imm_q;
      end
      default: ;
    endcase
    misalign = (jump || taken) && next_pc_d[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    bus.inst_ready      = 1'b0;
    bus.retire_valid    = 1'b0;
    bus.retire_pc       = '0;
    bus.retire_rd       = '0;
    bus.retire_we       = 1'b0;
    bus.retire_data     = '0;
    bus.retire_illegal  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_COMMIT;
      S_COMMIT: begin
        bus.retire_valid   = 1'b1;
        bus.retire_pc      = pc_q;
        bus.retire_rd      = we_q ? rd : 5'd0;
        bus.retire_we      = we_q;
        bus.retire_data    = we_q ? result_q : '0;
        bus.retire_illegal = illegal_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_q    <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
      pc_q      <= RESET_PC;
      legal_q   <= 1'b0;
      writes_q  <= 1'b0;
      illegal_q <= 1'b0;
      we_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.inst_valid) inst_q <= bus.inst;
        S_DECODE: begin
          imm_q    <= imm_d;
          legal_q  <= legal_d;
          writes_q <= writes_d;
        end
        S_READ: begin
          rs1_q <= rs1_val;
          rs2_q <= rs2_val;
        end
        S_EXEC: begin
          result_q  <= result_d;
          next_pc_q <= next_pc_d;
          illegal_q <= !legal_q || misalign;
          we_q      <= legal_q && !misalign && writes_q && (rd != 5'd0);
        end
        S_COMMIT: begin
          if (!illegal_q) pc_q <= next_pc_q;
          // x0 is never a write target, so its storage stays at the reset zero
          for (int i = 1; i < NUM_REGS; i++)
            if (we_q && rd == 5'(i)) regs_q[i] <= result_q;
        end
        default: ;
      endcase
    end
  end

  assign pc_o = pc_q;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign port_regfile[XLEN*g +: XLEN] = regs_q[g];
  end
endmodule

// File: tb/tb_riscv_multicycle_ref_model.sv
// tb/tb_riscv_multicycle_ref_model.sv - random and directed checks against an ISA-level model
module tb_riscv_multicycle_ref_model;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   pc_o;
  logic [511:0]  port_regfile;
  int            n_cmp = 0;
  int            n_bad = 0;

  riscv_multicycle_ref_model_if #(.XLEN(32)) bus ();

  riscv_multicycle_ref_model #(.XLEN(32), .NUM_REGS(NR), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .pc_o(pc_o), .port_regfile(port_regfile)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        illegal;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] npc;
  } exp_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] rget(input logic [4:0] i);
    return (i == 0 || i >= NR) ? 32'h0 : m_regs[i];
  endfunction

  function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
    return (a[31] != b[31]) ? a[31] : (a < b);
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] r;
    s = b[4:0];
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << s;
      3'd2: r = {31'b0, slt(a, b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: r = (a >> s) | ((alt && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic exp_t ref_step(input logic [31:0] w);
    exp_t        e;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, imm_i, imm_b, imm_j, imm_u, res;
    logic        ok, wr, u1, u2, ud, jump, taken;
    opc = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
    a = rget(rs1); b = rget(rs2);
    imm_i = {{20{w[31]}}, w[31:20]};
    imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    imm_u = {w[31:12], 12'h0};
    ok = 1; wr = 0; u1 = 0; u2 = 0; ud = 0; jump = 0; taken = 0; res = 0;
    e = '0;
    e.npc = m_pc + 4;
    case (opc)
      7'h33: begin
        wr = 1; u1 = 1; u2 = 1; ud = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        res = alu(f3, f7 == 7'h20, a, b);
      end
      7'h13: begin
        wr = 1; u1 = 1; ud = 1;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
        res = alu(f3, f3 == 5 && f7 == 7'h20, a, imm_i);
      end
      7'h37: begin wr = 1; ud = 1; res = imm_u; end
      7'h17: begin wr = 1; ud = 1; res = m_pc + imm_u; end
      7'h6F: begin wr = 1; ud = 1; res = m_pc + 4; e.npc = m_pc + imm_j; jump = 1; end
      7'h67: begin
        wr = 1; u1 = 1; ud = 1; ok = (f3 == 0);
        res = m_pc + 4; e.npc = (a + imm_i) & 32'hFFFF_FFFE; jump = 1;
      end
      7'h63: begin
        u1 = 1; u2 = 1; ok = (f3 != 2) && (f3 != 3);
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = slt(a, b);
          3'd5: taken = !slt(a, b);
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 0;
        endcase
        if (taken) e.npc = m_pc + imm_b;
      end
      default: ok = 0;
    endcase
    if ((u1 && rs1 >= NR) || (u2 && rs2 >= NR) || (ud && rd >= NR)) ok = 0;
    if ((jump || taken) && e.npc[1]) ok = 0;
    e.illegal = !ok;
    e.we      = ok && wr && (rd != 0);
    e.rd      = e.we ? rd : 5'd0;
    e.data    = e.we ? res : 32'h0;
    return e;
  endfunction

  function automatic logic [511:0] flat();
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = 32'h0;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after commit.
  task automatic run_inst(input logic [31:0] w);
    exp_t        e;
    logic [31:0] pc0;
    e   = ref_step(w);
    pc0 = m_pc;
    check("ready_idle", bus.inst_ready, 1);
    bus.inst_valid = 1'b1;
    bus.inst       = w;
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    bus.inst       = $urandom;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("busy", {bus.inst_ready, bus.retire_valid}, 0);
    end
    @(negedge clk);
    check("retire_valid", bus.retire_valid, 1);
    check("ready_commit", bus.inst_ready, 0);
    check("retire_pc", bus.retire_pc, pc0);
    check("retire_illegal", bus.retire_illegal, e.illegal);
    check("retire_we", bus.retire_we, e.we);
    check("retire_rd", bus.retire_rd, e.rd);
    check("retire_data", bus.retire_data, e.data);
    if (!e.illegal) m_pc = e.npc;
    if (e.we) m_regs[e.rd] = e.data;
    @(negedge clk);
    check("retire_drop", bus.retire_valid, 0);
    check("pc_o", pc_o, m_pc);
    check("regfile", port_regfile, flat());
  endtask

  function automatic logic [4:0] ridx();
    return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    rd = ridx(); rs1 = ridx(); rs2 = ridx();
    f3 = 3'($urandom);
    f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
    i12 = 12'($urandom);
    b13 = 13'($urandom) & 13'h1FFE;
    if ($urandom_range(0, 3) != 0) b13[1] = 1'b0;
    j21 = 21'($urandom) & 21'h1FFFFE;
    if ($urandom_range(0, 3) != 0) j21[1] = 1'b0;
    case ($urandom_range(0, 9))
      0: return {f7, rs2, rs1, f3, rd, 7'h33};
      1: begin
        if (f3 == 1 || f3 == 5) i12[11:5] = f7;
        return {i12, rs1, f3, rd, 7'h13};
      end
      2: return {20'($urandom), rd, 7'h37};
      3: return {20'($urandom), rd, 7'h17};
      4: return {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F};
      5: return {i12, rs1, ($urandom_range(0, 4) == 0) ? f3 : 3'd0, rd, 7'h67};
      6, 7: return {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
      8: return $urandom;
      default: return {i12, rs1, 3'd0, rd, 7'h13};
    endcase
  endfunction

  initial begin
    int acc, ret;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'h0;
    model_reset();
    #1;
    check("rst_ready", bus.inst_ready, 1);
    check("rst_retire", {bus.retire_valid, bus.retire_we, bus.retire_illegal, bus.retire_rd,
                         bus.retire_pc, bus.retire_data}, 0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_regfile", port_regfile, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_inst(32'hFFF00093);
    check("addi_x1", port_regfile[63:32], 32'hFFFF_FFFF);
    check("addi_pc", pc_o, 32'h4);
    run_inst(32'h4040D113);
    check("srai_x2", port_regfile[95:64], 32'hFFFF_FFFF);
    run_inst(32'h01C0D193);
    check("srli_x3", port_regfile[127:96], 32'h0000_000F);
    run_inst(32'h0000F463);
    check("bgeu_pc", pc_o, 32'h14);
    run_inst(32'h00500013);
    check("x0_pc", pc_o, 32'h18);
    check("x0_zero", port_regfile[31:0], 32'h0);
    run_inst(32'h0000007F);
    check("ill_op_pc", pc_o, 32'h18);
    run_inst(32'h00100A13);
    check("ill_idx_pc", pc_o, 32'h18);

    for (int n = 0; n < 200; n++) run_inst(gen_inst());

    // inst_valid held high: one acceptance per five cycles
    acc = 0;
    ret = 0;
    bus.inst_valid = 1'b1;
    bus.inst       = 32'h00128293;
    for (int j = 0; j < 25; j++) begin
      if (bus.inst_ready) acc++;
      if (bus.retire_valid) ret++;
      @(negedge clk);
    end
    bus.inst_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      exp_t e;
      e = ref_step(32'h00128293);
      m_pc = e.npc;
      if (e.we) m_regs[e.rd] = e.data;
    end
    check("bp_accepts", acc, 5);
    check("bp_retires", ret, 5);
    check("bp_pc", pc_o, m_pc);
    check("bp_regfile", port_regfile, flat());

    // reset while the instruction sits in EXEC
    ret = 0;
    bus.inst_valid = 1'b1;
    bus.inst       = 32'h00700313;
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.retire_valid) ret++;
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    check("abort_ready", bus.inst_ready, 1);
    check("abort_pc", pc_o, 32'h0);
    check("abort_regfile", port_regfile, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.retire_valid) ret++;
    end
    check("abort_no_retire", ret, 0);
    check("abort_regfile_after", port_regfile, flat());
    run_inst(32'h00700313);
    check("post_abort_x6", port_regfile[223:192], 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_ref_model.md
# riscv_multicycle_ref_model

Parametrised, multi-cycle architectural reference model of an RV32I-subset hart for formal and simulation checking of the Sodor core. It accepts one instruction word per valid/ready handshake and executes it as an explicit micro-operation sequence: decode, register read, execute, commit. Architectural state consists of the register file and the pc. Each commit is reported on a one-cycle retire port so a checker can compare it against DUT retirement. It supersedes the single-cycle model, adding:
- configurable register count
- U/J-type instructions
- correct arithmetic shifts and BGEU
- x0 hardwiring
- illegal-instruction reporting

## Interface
- XLEN, 32: datapath width (32 or 64); shifts use the low log2(XLEN) bits.
- NUM_REGS, 32: architectural registers (16 = RV32E style); register indices >= NUM_REGS are illegal.
- RESET_PC, 0: pc value after reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction word present.
- inst_ready  out  1  model can accept an instruction.
- inst  in  32  instruction word; sampled on handshake.
- retire_valid  out  1  one-cycle pulse; instruction committed or rejected.
- retire_pc  out  XLEN  pc of the retiring instruction.
- retire_rd  out  5  destination index (0 if no write).
- retire_we  out  1  register write performed.
- retire_data  out  XLEN  value written (0 if retire_we=0).
- retire_illegal  out  1  instruction rejected; no state change.
- pc_o  out  XLEN  current architectural pc.
- port_regfile  out  XLEN*NUM_REGS  flattened register file; register i at bits [XLEN*i +: XLEN].

## Operation
- States: IDLE -> DECODE -> READ -> EXEC -> COMMIT -> IDLE. The sequence is fixed; no stage is skipped.
- **IDLE**
  - inst_ready=1.
  - On inst_valid&&inst_ready, latch inst and go to DECODE; otherwise stay.
- **DECODE**
  - Extract opcode, rd, rs1, rs2, funct3, funct7.
  - Build the sign-extended immediate (I/B/U/J) to XLEN.
  - Evaluate legality.
- **READ**
  - Latch rs1_data and rs2_data from the register file.
  - Index 0 always reads 0.
- **EXEC**
  - Compute the result and next_pc.
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: the same set minus SUB.
  - SRA/SRAI are true arithmetic shifts.
  - LUI: rd = imm<<12. AUIPC: rd = pc + (imm<<12).
  - JAL: rd = pc+4, next_pc = pc+imm.
  - JALR: rd = pc+4, next_pc = (rs1+imm) & ~1.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU; taken -> pc+imm, not taken -> pc+4.
  - All other instructions: next_pc = pc+4.
  - All arithmetic wraps modulo 2^XLEN.
- **COMMIT**
  - retire_* valid for this cycle only.
  - rd written if legal, the opcode writes, and rd != 0.
  - pc <= next_pc if legal.
- **Illegal instruction**, any of:
  - unsupported opcode;
  - R-type funct7 not 0, or 0100000 with funct3 not 0/5;
  - shift-immediate with an invalid funct7;
  - branch funct3 2/3;
  - JALR funct3 != 0;
  - any used register index >= NUM_REGS;
  - a taken branch or jump target with bit 1 set.
- **Illegal instruction, behaviour**: retire_illegal=1, retire_we=0, retire_rd=0, retire_data=0; pc and the register file are unchanged.
- **x0 write**: a write to x0 is discarded; retire_we=0, retire_rd=0.

## Timing
- **Reset** (reset_n low, asynchronous):
  - state=IDLE, all registers 0, pc=RESET_PC;
  - inst_ready=1, all retire_* 0, pc_o=RESET_PC.
  - Deassertion is synchronised by the environment.
- **Latency**: handshake at edge t -> DECODE t+1, READ t+2, EXEC t+3, COMMIT t+4.
  - retire_valid is high during cycle t+4.
  - Register file and pc_o show the new values from t+5.
- **Throughput**: one instruction per 5 cycles; inst_ready=0 in DECODE through COMMIT.
- **Back-pressure**: inst may change while inst_ready=0; only the value at the handshake edge is used.
- **Reset mid-instruction**: the in-flight instruction is discarded with no retire pulse and no state write.
- **Read-after-write**: the next instruction's READ stage sees the committed value; there is no bypass hazard.

## Test plan
- Reset, then ADDI x1,x0,-1 (0xFFF00093) at t -> retire_valid at t+4, retire_rd=1, retire_data=0xFFFFFFFF, retire_pc=0; x1=0xFFFFFFFF and pc_o=4 at t+5.
- With x1=0xFFFFFFFF:
  - SRAI x2,x1,4 (0x4040D113) -> x2=0xFFFFFFFF.
  - SRLI x3,x1,28 (0x01C0D193) -> x3=0x0000000F.
- BGEU x1,x0,+8 (0x0000F463) at pc=0x0C -> taken, pc_o=0x14, retire_we=0.
- ADDI x0,x0,5 (0x00500013) -> retire_we=0, retire_rd=0, x0 stays 0, pc advances 4.
- Illegal cases -> retire_illegal=1, pc and regfile unchanged:
  - opcode 0x7F;
  - with NUM_REGS=16, ADDI x20,x0,1 (0x00100A13).
- Back-pressure and reset abort:
  - inst_valid held high across a busy instruction -> exactly one accept per 5 cycles.
  - reset_n pulsed low in EXEC -> no retire pulse, regfile 0, pc_o=RESET_PC, inst_ready=1.
